// File: rtl/fpadd_arbiter.sv
// Two-requester front end for one shared pipelined fpadd, with drain/flush control.
// Build with FPARB_FIXED_PRIO_EN defined to make requester 0 always win contention.
module fpadd_arbiter #(
    parameter int W   = 32,
    parameter int LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req0_ready,
    output logic         req1_ready,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_out,
    output logic         res0_valid,
    output logic         res1_valid,
    output logic [W-1:0] res_data,
    input  logic         drain,
    output logic         drained,
    output logic         busy
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [LAT:1]  tag_v;
    logic [LAT:1]  tag_id;
    logic          open_g;
    logic          gnt1;
    logic          acc0, acc1, acc;
    logic          res_v;

    // Grants are closed while draining and while reset is held.
    assign open_g = (state == RUN) && !drain && !rst;

`ifdef FPARB_FIXED_PRIO_EN
    assign gnt1 = req1_valid && !req0_valid;
`else
    logic last;

    assign gnt1 = req1_valid && (!req0_valid || !last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (acc)
            last <= acc1;
    end
`endif

    assign req0_ready = open_g && !gnt1;
    assign req1_ready = open_g && gnt1;

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;
    assign acc  = acc0 || acc1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a <= '0;
            add_b <= '0;
        end else if (acc1) begin
            add_a <= req1_a;
            add_b <= req1_b;
        end else if (acc0) begin
            add_a <= req0_a;
            add_b <= req0_b;
        end
    end

    // Tag stage k is valid k-1 cycles after acceptance; stage LAT meets add_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            for (int i = LAT; i > 1; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            tag_v[1]  <= acc;
            tag_id[1] <= acc1;
        end
    end

    assign res_v      = tag_v[LAT];
    assign res0_valid = res_v && !tag_id[LAT];
    assign res1_valid = res_v && tag_id[LAT];
    assign res_data   = rst ? '0 : add_out;

    always_comb begin
        count_nxt = count;
        unique case ({acc, res_v})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else
            count <= count_nxt;
    end

    assign busy = (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // DRAIN looks at the post-edge count so drained follows the last result directly.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (drain) state_nxt = DRAIN;
            DRAIN:   if (count_nxt == '0) state_nxt = DONE;
            DONE:    if (!drain) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign drained = (state == DONE);

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter: grant table, single op, drain, reset, LAT=1 stream.
// A small fpadd model and a result scoreboard stand in for the shared adder.
module tb_fpadd_arbiter;

    localparam int W   = 32;
    localparam int LAT = 3;

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         v0, v1, r0, r1, rv0, rv1, drain, drained, busy;
    logic [W-1:0] a0, b0, a1, b1, adda, addb, aout, rdata;

    logic         s_v0, s_r0, s_r1, s_rv0, s_rv1, s_drained, s_busy;
    logic [W-1:0] s_a0, s_b0, s_adda, s_addb, s_aout, s_rdata;
    logic         s_v1, s_drain;
    logic [W-1:0] s_a1, s_b1;

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {F1, F1}: return F2;
            {F2, F2}: return F4;
            {F1, F2}: return F3;
            {F2, F1}: return F3;
            default:  return x + y;
        endcase
    endfunction

    fpadd_arbiter #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1),
        .req0_ready(r0), .req1_ready(r1),
        .add_a(adda), .add_b(addb), .add_out(aout),
        .res0_valid(rv0), .res1_valid(rv1), .res_data(rdata),
        .drain(drain), .drained(drained), .busy(busy)
    );

    fpadd_arbiter #(.W(W), .LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(s_v0), .req0_a(s_a0), .req0_b(s_b0),
        .req1_valid(s_v1), .req1_a(s_a1), .req1_b(s_b1),
        .req0_ready(s_r0), .req1_ready(s_r1),
        .add_a(s_adda), .add_b(s_addb), .add_out(s_aout),
        .res0_valid(s_rv0), .res1_valid(s_rv1), .res_data(s_rdata),
        .drain(s_drain), .drained(s_drained), .busy(s_busy)
    );

    // Adder model: LAT-1 register stages after add_a/add_b.
    logic [W-1:0] pipe [0:LAT-2];
    always @(posedge clk) begin
        pipe[0] <= fadd(adda, addb);
        for (int i = 1; i <= LAT - 2; i++)
            pipe[i] <= pipe[i-1];
    end
    assign aout   = pipe[LAT-2];
    assign s_aout = fadd(s_adda, s_addb);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        ch;
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic        pend = 1'b0;
    logic [31:0] pa, pb;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("add_a", adda, pa);
                chk("add_b", addb, pb);
                pend = 1'b0;
            end
            if (rv0 || rv1) begin
                if (q.size() == 0) begin
                    chk("unexpected_res", {30'b0, rv1, rv0}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("res_onehot", {31'b0, rv0 & rv1}, 32'd0);
                    chk("res_ch", {31'b0, rv1}, {31'b0, e.ch});
                    chk("res_data", rdata, e.d);
                    chk("res_time", cyc, e.due);
                end
            end else if (q.size() > 0 && cyc > q[0].due) begin
                chk("res_missing", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (v0 && r0) begin
                e.ch = 1'b0; e.d = fadd(a0, b0); e.due = cyc + LAT;
                q.push_back(e);
                pend = 1'b1; pa = a0; pb = b0;
            end else if (v1 && r1) begin
                e.ch = 1'b1; e.d = fadd(a1, b1); e.due = cyc + LAT;
                q.push_back(e);
                pend = 1'b1; pa = a1; pb = b1;
            end
        end
    end

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0, a1, b1;
        logic        e0, e1;
    } vec_t;

    vec_t vt [10];

    function automatic vec_t mk(input logic iv0, input logic iv1,
                                input logic [31:0] ia0, input logic [31:0] ib0,
                                input logic [31:0] ia1, input logic [31:0] ib1,
                                input logic rr0, input logic rr1,
                                input logic fp0, input logic fp1);
        vec_t r;
        r.v0 = iv0; r.v1 = iv1;
        r.a0 = ia0; r.b0 = ib0; r.a1 = ia1; r.b1 = ib1;
`ifdef FPARB_FIXED_PRIO_EN
        r.e0 = fp0; r.e1 = fp1;
`else
        r.e0 = rr0; r.e1 = rr1;
`endif
        return r;
    endfunction

    initial begin
        int n;
        int k;
        vt[0] = mk(1, 1, F1, F1, F2, F2, 1, 0, 1, 0);
        vt[1] = mk(1, 1, F1, F1, F2, F2, 0, 1, 1, 0);
        vt[2] = mk(1, 1, F1, F1, F2, F2, 1, 0, 1, 0);
        vt[3] = mk(1, 1, F1, F1, F2, F2, 0, 1, 1, 0);
        vt[4] = mk(0, 0, F1, F1, F2, F2, 1, 0, 1, 0);
        vt[5] = mk(0, 1, F1, F1, F1, F2, 0, 1, 0, 1);
        vt[6] = mk(1, 1, F2, F2, F1, F1, 1, 0, 1, 0);
        vt[7] = mk(1, 0, F1, F2, F2, F2, 1, 0, 1, 0);
        vt[8] = mk(1, 1, F1, F1, F2, F1, 0, 1, 1, 0);
        vt[9] = mk(0, 0, F1, F1, F2, F2, 1, 0, 1, 0);

        rst = 1'b1; drain = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        a0 = F1; b0 = F1; a1 = F2; b1 = F2;
        s_v0 = 1'b0; s_v1 = 1'b0; s_drain = 1'b0;
        s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;

        @(negedge clk);
        chk("rst_ready0", {31'b0, r0}, 32'd0);
        chk("rst_ready1", {31'b0, r1}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_drained", {31'b0, drained}, 32'd0);
        chk("rst_res", {30'b0, rv1, rv0}, 32'd0);
        chk("rst_add_a", adda, 32'd0);
        chk("rst_res_data", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;

        for (int i = 0; i < 10; i++) begin
            v0 = vt[i].v0; v1 = vt[i].v1;
            a0 = vt[i].a0; b0 = vt[i].b0;
            a1 = vt[i].a1; b1 = vt[i].b1;
            @(negedge clk);
            chk($sformatf("vec%0d_ready0", i), {31'b0, r0}, {31'b0, vt[i].e0});
            chk($sformatf("vec%0d_ready1", i), {31'b0, r1}, {31'b0, vt[i].e1});
            @(posedge clk); #1;
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        // Single op latency
        v0 = 1'b1; a0 = F1; b0 = F2;
        @(negedge clk);
        chk("single_ready", {31'b0, r0}, 32'd1);
        @(posedge clk); #1;
        v0 = 1'b0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rv0) begin
                k = i;
                break;
            end
        end
        chk("single_latency", k, LAT);
        chk("single_data", rdata, F3);
        @(posedge clk); #1;

        // Drain
        v0 = 1'b1; a0 = F1; b0 = F1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_accept", {31'b0, r0}, 32'd1);
            @(posedge clk); #1;
        end
        drain = 1'b1;
        @(negedge clk);
        chk("drain_block", {31'b0, r0}, 32'd0);
        n = rv0 ? 1 : 0;
        v0 = 1'b0;
        for (int i = 0; i < 12 && n < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("drain_not_done", {31'b0, drained}, 32'd0);
            if (rv0) n++;
        end
        chk("drain_results", n, 3);
        @(posedge clk);
        @(negedge clk);
        chk("drained_rise", {31'b0, drained}, 32'd1);
        chk("drained_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        drain = 1'b0; v0 = 1'b1; a0 = F2; b0 = F2;
        @(negedge clk);
        chk("done_ready", {31'b0, r0}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rerun_ready", {31'b0, r0}, 32'd1);
        chk("rerun_drained", {31'b0, drained}, 32'd0);
        @(posedge clk); #1;
        v0 = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Reset with two ops in flight
        v0 = 1'b1; a0 = F1; b0 = F1;
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b1; a1 = F2; b1 = F2;
        @(posedge clk); #1;
        v1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; v0 = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_ready0", {31'b0, r0}, 32'd0);
        chk("midrst_res", {30'b0, rv1, rv0}, 32'd0);
        chk("midrst_add_a", adda, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; v0 = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            chk("postrst_res", {30'b0, rv1, rv0}, 32'd0);
            chk("postrst_busy", {31'b0, busy}, 32'd0);
        end
        @(posedge clk); #1;
        v0 = 1'b1; v1 = 1'b1; a0 = F1; b0 = F1; a1 = F2; b1 = F2;
        @(negedge clk);
        chk("postrst_win0", {31'b0, r0}, 32'd1);
        chk("postrst_win1", {31'b0, r1}, 32'd0);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;

        // LAT=1 continuous stream
        s_v0 = 1'b1; s_a0 = F1; s_b0 = F2;
        @(negedge clk);
        chk("lat1_ready", {31'b0, s_r0}, 32'd1);
        chk("lat1_busy0", {31'b0, s_busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("lat1_busy", {31'b0, s_busy}, 32'd1);
            chk("lat1_res", {31'b0, s_rv0}, 32'd1);
            chk("lat1_data", s_rdata, F3);
            chk("lat1_ready_s", {31'b0, s_r0}, 32'd1);
        end
        @(posedge clk); #1;
        s_v0 = 1'b0;
        @(negedge clk);
        chk("lat1_tail_res", {31'b0, s_rv0}, 32'd1);
        chk("lat1_tail_busy", {31'b0, s_busy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1_idle_res", {31'b0, s_rv0}, 32'd0);
        chk("lat1_idle_busy", {31'b0, s_busy}, 32'd0);

        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
